// File: rtl/uart_bram_echo_fifo.sv
// BRAM-backed byte FIFO between UART RX and TX with a start/done transmit sequencer.
// Optional macro UART_ECHO_LINE_MODE_EN holds bytes until a CR-terminated line (or a full FIFO) is buffered.
module uart_bram_echo_fifo #(
  parameter int ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              En,
  input  logic [7:0]        RxByte,
  input  logic              RxDataValid,
  input  logic              TxDone,
  output logic [7:0]        TxByte,
  output logic              TxDataValid,
  output logic              TxActive,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [7:0]        ram_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [1:0]        state;
  logic              wr_en, pop, drain_ok;

  assign wr_en    = RxDataValid && !Full;
  assign pop      = (state == S_IDLE) && drain_ok && En;
  assign TxActive = (state == S_WAIT);

  // Registered read: the byte at rd_ptr is in ram_q during LOAD.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= RxByte;
    ram_q <= mem[rd_ptr];
  end

  always_comb begin
    count_nxt = Count;
    case ({wr_en, pop})
      2'b10:   count_nxt = Count + 1'b1;
      2'b01:   count_nxt = Count - 1'b1;
      default: count_nxt = Count;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      Count    <= count_nxt;
      Full     <= (count_nxt == DEPTH);
      Empty    <= (count_nxt == '0);
      Overflow <= Overflow | (RxDataValid && Full);
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state       <= S_IDLE;
      TxByte      <= 8'h00;
      TxDataValid <= 1'b0;
    end else begin
      TxDataValid <= 1'b0;
      case (state)
        S_IDLE: if (pop) state <= S_LOAD;
        S_LOAD: begin
          TxByte      <= ram_q;
          TxDataValid <= 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: if (TxDone) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_ECHO_LINE_MODE_EN
  logic [ADDR_W:0] line_cnt;
  logic            cr_in, cr_out;

  // A popped CR is only visible in LOAD; the next IDLE sees the updated count.
  assign cr_in  = wr_en && (RxByte == 8'h0D);
  assign cr_out = (state == S_LOAD) && (ram_q == 8'h0D);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) line_cnt <= '0;
    else begin
      case ({cr_in, cr_out})
        2'b10:   line_cnt <= line_cnt + 1'b1;
        2'b01:   line_cnt <= line_cnt - 1'b1;
        default: line_cnt <= line_cnt;
      endcase
    end
  end

  assign drain_ok = !Empty && ((line_cnt != '0) || Full);
`else
  assign drain_ok = !Empty;
`endif

endmodule
